// File: rtl/prbs4_stream_if.sv
// Stream interface between the 4-bit random-sequence source and its checker.
//   in_data / in_valid / clr_err : driven by the source side (master)
//   locked, err_pulse, lock_lost,
//   err_count[ERR_W], state[2]   : status returned by the checker (slave)
interface prbs4_stream_if #(
    parameter int ERR_W = 16
);
    logic [3:0]       in_data;
    logic             in_valid;
    logic             clr_err;
    logic             locked;
    logic             err_pulse;
    logic             lock_lost;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state;

    modport master (
        output in_data, in_valid, clr_err,
        input  locked, err_pulse, lock_lost, err_count, state
    );

    modport slave (
        input  in_data, in_valid, clr_err,
        output locked, err_pulse, lock_lost, err_count, state
    );
endinterface

// File: rtl/prbs4_stream_checker.sv
// BIST checker for the 4-bit pseudo-random source (x -> {x[2:0], x[3]^x[2]}).
// Synchronises to the incoming stream, then flywheels its own prediction and
// flags/counts every word that disagrees.
//   clk       : rising-edge clock
//   rst       : asynchronous, active-high reset
//   bus.slave : in_data/in_valid sample, clr_err counter clear;
//               locked, err_pulse, lock_lost, err_count, state (all registered)
module prbs4_stream_checker #(
    parameter int LOCK_COUNT  = 3,
    parameter int LOSS_THRESH = 2,
    parameter int ERR_W       = 16
) (
    input  logic           clk,
    input  logic           rst,
    prbs4_stream_if.slave  bus
);
    localparam int MW = (LOCK_COUNT  > 1) ? $clog2(LOCK_COUNT + 1)  : 1;
    localparam int LW = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH + 1) : 1;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_t;

    function automatic logic [3:0] next_word(input logic [3:0] x);
        return {x[2:0], x[3] ^ x[2]};
    endfunction

    state_t           state_q,  state_n;
    logic [3:0]       exp_q,    exp_n;
    logic [MW-1:0]    match_q,  match_n;
    logic [LW-1:0]    miss_q,   miss_n;
    logic [ERR_W-1:0] err_q,    err_n;
    logic             locked_q, locked_n;
    logic             epulse_q, epulse_n;
    logic             llost_q,  llost_n;

    logic [3:0]       pred;
    logic             hit;
    logic             zero;
    logic             count_err;
    logic [ERR_W-1:0] err_base;

    assign pred = next_word(exp_q);
    assign hit  = (bus.in_data == pred);
    assign zero = (bus.in_data == 4'b0000);

    always_comb begin
        state_n   = state_q;
        exp_n     = exp_q;
        match_n   = match_q;
        miss_n    = miss_q;
        locked_n  = locked_q;
        epulse_n  = 1'b0;
        llost_n   = 1'b0;
        count_err = 1'b0;

        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    // 0000 is the lock-up word: it can never be a valid seed.
                    if (!zero) begin
                        exp_n   = bus.in_data;
                        match_n = '0;
                        state_n = VERIFY;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        exp_n = bus.in_data;
                        if (match_q == MW'(LOCK_COUNT - 1)) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                            miss_n   = '0;
                            match_n  = MW'(LOCK_COUNT);
                        end else begin
                            match_n = match_q + MW'(1);
                        end
                    end else if (!zero) begin
                        // Wrong guess while still synchronising: reseed quietly.
                        exp_n   = bus.in_data;
                        match_n = '0;
                    end else begin
                        state_n = HUNT;
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the received word never reseeds once locked,
                    // so a single corrupted word costs exactly one error.
                    exp_n = pred;
                    if (hit) begin
                        miss_n = '0;
                    end else begin
                        epulse_n  = 1'b1;
                        count_err = 1'b1;
                        if (miss_q == LW'(LOSS_THRESH - 1)) begin
                            state_n  = HUNT;
                            locked_n = 1'b0;
                            llost_n  = 1'b1;
                            miss_n   = '0;
                        end else begin
                            miss_n = miss_q + LW'(1);
                        end
                    end
                end
                default: begin
                    state_n  = HUNT;
                    locked_n = 1'b0;
                end
            endcase
        end

        // Clear takes effect first so a coincident error leaves a count of 1.
        err_base = bus.clr_err ? '0 : err_q;
        err_n    = err_base;
        if (count_err && (err_base != '1))
            err_n = err_base + ERR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            exp_q    <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            err_q    <= '0;
            locked_q <= 1'b0;
            epulse_q <= 1'b0;
            llost_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            exp_q    <= exp_n;
            match_q  <= match_n;
            miss_q   <= miss_n;
            err_q    <= err_n;
            locked_q <= locked_n;
            epulse_q <= epulse_n;
            llost_q  <= llost_n;
        end
    end

    assign bus.state     = state_q;
    assign bus.locked    = locked_q;
    assign bus.err_pulse = epulse_q;
    assign bus.lock_lost = llost_q;
    assign bus.err_count = err_q;

endmodule
